// File: rtl/fpu_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa
// division, one quotient bit per clock, round-to-nearest-even, flush-to-zero.
//
// state | meaning
// IDLE  | waiting for En; Done released
// CALC  | restoring division, one quotient bit per edge
// SPEC  | special-operand result being formed
// DONE  | normalise/round (or pass special), register Result/Flags, pulse Done
module fpu_div_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        En,
    input  logic [31:0] Rs1,
    input  logic [31:0] Rs2,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [4:0]  Flags
);

    localparam int QBITS = 26;

    typedef enum logic [1:0] {IDLE, CALC, SPEC, DONE} state_t;

    state_t      state;
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [25:0] rem;
    logic [25:0] q;
    logic [4:0]  cnt;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    logic        in_special;
    logic [26:0] trial;

    // Exponent 0 (zero/denormal, flushed) or 255 (inf/NaN) takes the special path.
    assign in_special = (Rs1[30:23] == 8'h00) || (Rs1[30:23] == 8'hFF) ||
                        (Rs2[30:23] == 8'h00) || (Rs2[30:23] == 8'hFF);

    assign trial = {1'b0, rem} - {3'b000, mb};

    // Special-case classification on the latched operands
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [31:0] spec_res_c;
    logic [4:0]  spec_flags_c;

    always_comb begin
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (ma[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (ma[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb[22:0] != 23'd0);
        spec_res_c   = {sign, 31'd0};
        spec_flags_c = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res_c   = 32'h7FC00000;
            spec_flags_c = 5'b10000;
        end else if (a_inf) begin
            spec_res_c = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res_c   = {sign, 8'hFF, 23'd0};
            spec_flags_c = 5'b01000;
        end
    end

    // Normalise, round to nearest even, range check
    logic signed [9:0] e_raw, e_adj, e_fin;
    logic [22:0]       frac;
    logic [23:0]       frac_inc;
    logic              g, s, rnd;
    logic [31:0]       norm_res;
    logic [4:0]        norm_flags;

    always_comb begin
        e_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (q[25]) begin
            frac  = q[24:2];
            g     = q[1];
            s     = q[0] | (rem != 26'd0);
            e_adj = e_raw;
        end else begin
            frac  = q[23:1];
            g     = q[0];
            s     = (rem != 26'd0);
            e_adj = e_raw - 10'sd1;
        end
        rnd      = g & (s | frac[0]);
        frac_inc = {1'b0, frac} + {23'd0, rnd};
        // A carry out leaves the fraction at zero, i.e. mantissa 1.0 one binade up
        e_fin    = e_adj + $signed({9'd0, frac_inc[23]});
        if (e_fin >= 10'sd255) begin
            norm_res   = {sign, 8'hFF, 23'd0};
            norm_flags = 5'b00101;
        end else if (e_fin <= 10'sd0) begin
            norm_res   = {sign, 31'd0};
            norm_flags = 5'b00011;
        end else begin
            norm_res   = {sign, e_fin[7:0], frac_inc[22:0]};
            norm_flags = {4'b0000, g | s};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Result     <= 32'd0;
            Flags      <= 5'd0;
            sign       <= 1'b0;
            ea         <= 8'd0;
            eb         <= 8'd0;
            ma         <= 24'd0;
            mb         <= 24'd0;
            rem        <= 26'd0;
            q          <= 26'd0;
            cnt        <= 5'd0;
            spec_hit   <= 1'b0;
            spec_res   <= 32'd0;
            spec_flags <= 5'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (En) begin
                        sign     <= Rs1[31] ^ Rs2[31];
                        ea       <= Rs1[30:23];
                        eb       <= Rs2[30:23];
                        ma       <= {1'b1, Rs1[22:0]};
                        mb       <= {1'b1, Rs2[22:0]};
                        rem      <= {2'b00, 1'b1, Rs1[22:0]};
                        q        <= 26'd0;
                        cnt      <= 5'(QBITS - 1);
                        spec_hit <= in_special;
                        Busy     <= 1'b1;
                        state    <= in_special ? SPEC : CALC;
                    end
                end
                CALC: begin
                    if (!trial[26]) begin
                        q   <= {q[24:0], 1'b1};
                        rem <= trial[25:0] << 1;
                    end else begin
                        q   <= {q[24:0], 1'b0};
                        rem <= rem << 1;
                    end
                    if (cnt == 5'd0) state <= DONE;
                    else             cnt   <= cnt - 5'd1;
                end
                SPEC: begin
                    spec_res   <= spec_res_c;
                    spec_flags <= spec_flags_c;
                    state      <= DONE;
                end
                DONE: begin
                    Result <= spec_hit ? spec_res   : norm_res;
                    Flags  <= spec_hit ? spec_flags : norm_flags;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: arithmetic, rounding, specials, range,
// handshake and reset abort, each checked with an immediate assertion.
module tb_fpu_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    fpu_div_seq dut (
        .CLK(clk), .RST(rst), .En(en), .Rs1(rs1), .Rs2(rs2),
        .Busy(busy), .Done(done), .Result(result), .Flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at posedge+1, let the next edge accept it, then scramble operands.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        rs1 = a;
        rs2 = b;
        en  = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [31:0] exp_res, input logic [4:0] exp_flags);
        int n;
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check({tag, "_done"},    {31'd0, done}, 32'd1);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"},  result, exp_res);
        check({tag, "_flags"},   {27'd0, flags}, {27'd0, exp_flags});
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] r, input logic [4:0] f);
        start(a, b);
        check({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
        wait_done(tag, lat, r, f);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; en = 1'b0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags",  {27'd0, flags}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op("neg14_neg2", 32'hC1600000, 32'hC0000000, 27, 32'h40E00000, 5'b00000);
        op("3_2",        32'h40400000, 32'h40000000, 27, 32'h3FC00000, 5'b00000);
        op("m18p5_2",    32'hC1940000, 32'h40000000, 27, 32'hC1140000, 5'b00000);
        op("22_7",       32'h41B00000, 32'h40E00000, 27, 32'h40492492, 5'b00001);
        op("1_3",        32'h3F800000, 32'h40400000, 27, 32'h3EAAAAAB, 5'b00001);

        op("one_zero",   32'h3F800000, 32'h00000000, 2, 32'h7F800000, 5'b01000);
        op("zero_zero",  32'h00000000, 32'h00000000, 2, 32'h7FC00000, 5'b10000);
        op("inf_two",    32'h7F800000, 32'h40000000, 2, 32'h7F800000, 5'b00000);

        op("overflow",   32'h7F000000, 32'h3E800000, 27, 32'h7F800000, 5'b00101);
        op("underflow",  32'h00800000, 32'h41000000, 27, 32'h00000000, 5'b00011);

        // En pulses while busy are dropped
        start(32'h40400000, 32'h40000000);
        repeat (3) begin
            rs1 = 32'h3F800000; rs2 = 32'h40400000; en = 1'b1;
            @(posedge clk); #1;
            en = 1'b0;
        end
        wait_done("ignore_en", 24, 32'h3FC00000, 5'b00000);

        // Back-to-back: request in the Done cycle is accepted
        start(32'hC1600000, 32'hC0000000);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_first", 27, 32'h40E00000, 5'b00000);
        start(32'h41B00000, 32'h40E00000);
        check("b2b_accept", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", 27, 32'h40492492, 5'b00001);

        // Reset during CALC aborts with no Done
        start(32'h40400000, 32'h40000000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 32'd0);

        // Simultaneous RST and En: request lost
        rst = 1'b1; en = 1'b1; rs1 = 32'h40400000; rs2 = 32'h40000000;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        check("rst_en_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("rst_en_quiet", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
